mux_load_counter: RTL and testbench

MUX_LOAD_COUNTER -- requirements
Module: mux_load_counter

---
 rtl/mux_load_counter_pkg.sv | 12 +
 rtl/mux_load_seq.sv | 95 +++++++++
 rtl/mux_load_counter.sv | 67 ++++++
 tb/tb_mux_load_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_load_counter_pkg.sv
// Shared definitions for the mux-fed loadable up/down counter.
package mux_load_counter_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SETUP = 2'b01,
      ST_CAPT  = 2'b10
   } seq_state_e;

endpackage : mux_load_counter_pkg

// File: rtl/mux_load_seq.sv
// Load sequencer: drives the upstream selector (SEL/ENB_N), waits one settle
// cycle, then tells the datapath to capture and pulses LOAD_ACK.
module mux_load_seq
   import mux_load_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_n,
   input  logic load_req,
   input  logic src_b,
   output logic sel,
   output logic enb_n,
   output logic load_ack,
   output logic busy,
   output logic capture,
   output logic count_ok
);

   seq_state_e state_q, state_d;
   logic       sel_q, sel_d;
   logic       enb_n_q, enb_n_d;
   logic       load_ack_q, load_ack_d;

   // State register; reset parks the sequencer in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a clear aborts anything, and the unused code falls back to IDLE.
   always_comb begin
      state_d = ST_IDLE;
      if (clr_n) begin
         case (state_q)
            ST_IDLE:  state_d = load_req ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Next values of the registered selector controls and the acknowledge pulse.
   always_comb begin
      sel_d      = sel_q;
      enb_n_d    = 1'b1;
      load_ack_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_req) begin
               sel_d   = src_b;
               enb_n_d = 1'b0;
            end
         end
         ST_SETUP: begin
            enb_n_d = enb_n_q;
         end
         ST_CAPT: begin
            enb_n_d    = 1'b1;
            load_ack_d = 1'b1;
         end
         default: begin
            enb_n_d = 1'b1;
         end
      endcase
      if (!clr_n) begin
         enb_n_d    = 1'b1;
         load_ack_d = 1'b0;
      end
   end

   // Output registers; SEL keeps its last value across a synchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= 1'b0;
         enb_n_q    <= 1'b1;
         load_ack_q <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         enb_n_q    <= enb_n_d;
         load_ack_q <= load_ack_d;
      end
   end

   assign sel      = sel_q;
   assign enb_n    = enb_n_q;
   assign load_ack = load_ack_q;
   assign busy     = (state_q != ST_IDLE);
   assign capture  = (state_q == ST_CAPT);
   assign count_ok = (state_q == ST_IDLE) && !load_req;

endmodule : mux_load_seq

// File: rtl/mux_load_counter.sv
// Up/down counter with cascade enables, parallel-loaded through an external
// quad 2:1 selector under control of the load sequencer.
module mux_load_counter
   import mux_load_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] Y,
   input  logic             LOAD_REQ,
   input  logic             SRC_B,
   input  logic             CNT_EN,
   input  logic             CIN,
   input  logic             UP,
   input  logic             CLR_N,
   output logic             SEL,
   output logic             ENB_N,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             LOAD_ACK,
   output logic             BUSY
);

   logic             capture;
   logic             count_ok;
   logic [WIDTH-1:0] q_q, q_d;

   mux_load_seq u_seq (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .clr_n    (CLR_N),
      .load_req (LOAD_REQ),
      .src_b    (SRC_B),
      .sel      (SEL),
      .enb_n    (ENB_N),
      .load_ack (LOAD_ACK),
      .busy     (BUSY),
      .capture  (capture),
      .count_ok (count_ok)
   );

   // Counter next value: clear beats capture, capture beats counting.
   always_comb begin
      q_d = q_q;
      if (!CLR_N) begin
         q_d = '0;
      end else if (capture) begin
         q_d = Y;
      end else if (count_ok && CNT_EN && CIN) begin
         q_d = UP ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q   = q_q;
   assign RCO = CIN & (UP ? (&q_q) : ~(|q_q));

endmodule : mux_load_counter

// File: tb/tb_mux_load_counter.sv
// Directed self-checking bench for mux_load_counter.
module tb_mux_load_counter;

   logic       CLK;
   logic       RESET_N;
   logic [3:0] Y;
   logic       LOAD_REQ;
   logic       SRC_B;
   logic       CNT_EN;
   logic       CIN;
   logic       UP;
   logic       CLR_N;
   logic       SEL;
   logic       ENB_N;
   logic [3:0] Q;
   logic       RCO;
   logic       LOAD_ACK;
   logic       BUSY;

   int tests_run;
   int tests_failed;

   mux_load_counter #(.WIDTH(4)) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .Y        (Y),
      .LOAD_REQ (LOAD_REQ),
      .SRC_B    (SRC_B),
      .CNT_EN   (CNT_EN),
      .CIN      (CIN),
      .UP       (UP),
      .CLR_N    (CLR_N),
      .SEL      (SEL),
      .ENB_N    (ENB_N),
      .Q        (Q),
      .RCO      (RCO),
      .LOAD_ACK (LOAD_ACK),
      .BUSY     (BUSY)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // One active edge, then settle 1 time unit before sampling.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Loads a value with counting disabled; Q holds it on return.
   task automatic do_load(input logic [3:0] val, input logic src);
      Y        = val;
      SRC_B    = src;
      CNT_EN   = 1'b0;
      LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      Y = 4'h0; LOAD_REQ = 1'b0; SRC_B = 1'b0; CNT_EN = 1'b0;
      CIN = 1'b1; UP = 1'b0; CLR_N = 1'b1;
      RESET_N = 1'b1;
      #2 RESET_N = 1'b0;
      #1;
      tests_run++;
      if (Q !== 4'h0 || SEL !== 1'b0 || ENB_N !== 1'b1 || LOAD_ACK !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs got Q=%h SEL=%b ENB_N=%b ACK=%b BUSY=%b want 0 0 1 0 0",
                  Q, SEL, ENB_N, LOAD_ACK, BUSY);
      end
      tests_run++;
      if (RCO !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_rco got %b want 1", RCO);
      end
      tick();
      tick();
      RESET_N = 1'b1;
      CIN = 1'b0;
      #1;
      tests_run++;
      if (Q !== 4'h0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release got Q=%h BUSY=%b want 0 0", Q, BUSY);
      end
   endtask

   task automatic test_load_b();
      Y = 4'hA; SRC_B = 1'b1; LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      tests_run++;
      if (SEL !== 1'b1 || ENB_N !== 1'b0 || BUSY !== 1'b1 || Q !== 4'h0) begin
         tests_failed++;
         $display("[TB] FAIL load_b_edge1 got SEL=%b ENB_N=%b BUSY=%b Q=%h want 1 0 1 0",
                  SEL, ENB_N, BUSY, Q);
      end
      tick();
      tests_run++;
      if (BUSY !== 1'b1 || ENB_N !== 1'b0 || Q !== 4'h0 || LOAD_ACK !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL load_b_edge2 got BUSY=%b ENB_N=%b Q=%h ACK=%b want 1 0 0 0",
                  BUSY, ENB_N, Q, LOAD_ACK);
      end
      tick();
      tests_run++;
      if (Q !== 4'hA || LOAD_ACK !== 1'b1 || ENB_N !== 1'b1 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL load_b_edge3 got Q=%h ACK=%b ENB_N=%b BUSY=%b want a 1 1 0",
                  Q, LOAD_ACK, ENB_N, BUSY);
      end
      tick();
      tests_run++;
      if (LOAD_ACK !== 1'b0 || Q !== 4'hA || SEL !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL load_b_edge4 got ACK=%b Q=%h SEL=%b want 0 a 1", LOAD_ACK, Q, SEL);
      end
   endtask

   task automatic test_count_up();
      logic [3:0] exp_q  [4];
      logic       exp_rco[4];
      exp_q   = '{4'hE, 4'hF, 4'h0, 4'h1};
      exp_rco = '{1'b0, 1'b1, 1'b0, 1'b0};
      do_load(4'hE, 1'b0);
      UP = 1'b1; CNT_EN = 1'b1; CIN = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         tests_run++;
         if (Q !== exp_q[i] || RCO !== exp_rco[i]) begin
            tests_failed++;
            $display("[TB] FAIL count_up_%0d got Q=%h RCO=%b want %h %b", i, Q, RCO, exp_q[i], exp_rco[i]);
         end
      end
      CIN = 1'b0;
      tick();
      tests_run++;
      if (Q !== 4'h1 || RCO !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL count_cin_off got Q=%h RCO=%b want 1 0", Q, RCO);
      end
      do_load(4'hF, 1'b0);
      CIN = 1'b0; UP = 1'b1;
      #1;
      tests_run++;
      if (RCO !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rco_cin_gate got %b want 0", RCO);
      end
      CIN = 1'b1;
      #1;
      tests_run++;
      if (RCO !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rco_no_enp got %b want 1", RCO);
      end
   endtask

   task automatic test_count_down();
      logic [3:0] exp_q  [3];
      logic       exp_rco[3];
      exp_q   = '{4'h1, 4'h0, 4'hF};
      exp_rco = '{1'b0, 1'b1, 1'b0};
      do_load(4'h1, 1'b0);
      UP = 1'b0; CNT_EN = 1'b1; CIN = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         tests_run++;
         if (Q !== exp_q[i] || RCO !== exp_rco[i]) begin
            tests_failed++;
            $display("[TB] FAIL count_down_%0d got Q=%h RCO=%b want %h %b", i, Q, RCO, exp_q[i], exp_rco[i]);
         end
      end
      CNT_EN = 1'b0;
   endtask

   task automatic test_back_to_back();
      int acks;
      acks = 0;
      do_load(4'h3, 1'b1);
      Y = 4'h7; SRC_B = 1'b0; LOAD_REQ = 1'b1; CNT_EN = 1'b1; CIN = 1'b1; UP = 1'b1;
      tick();
      if (LOAD_ACK === 1'b1) acks++;
      tests_run++;
      if (Q !== 4'h3 || SEL !== 1'b0 || BUSY !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL collide_edge1 got Q=%h SEL=%b BUSY=%b want 3 0 1", Q, SEL, BUSY);
      end
      tick();
      if (LOAD_ACK === 1'b1) acks++;
      tests_run++;
      if (Q !== 4'h3) begin
         tests_failed++;
         $display("[TB] FAIL collide_edge2 got Q=%h want 3", Q);
      end
      tick();
      if (LOAD_ACK === 1'b1) acks++;
      LOAD_REQ = 1'b0; CNT_EN = 1'b0;
      tests_run++;
      if (Q !== 4'h7) begin
         tests_failed++;
         $display("[TB] FAIL collide_edge3 got Q=%h want 7", Q);
      end
      tick();
      if (LOAD_ACK === 1'b1) acks++;
      tick();
      if (LOAD_ACK === 1'b1) acks++;
      tests_run++;
      if (acks != 1 || Q !== 4'h7 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL collide_single_ack got acks=%0d Q=%h BUSY=%b want 1 7 0", acks, Q, BUSY);
      end
      Y = 4'hF;
      tick();
      Y = 4'h2;
      tick();
      tests_run++;
      if (Q !== 4'h7) begin
         tests_failed++;
         $display("[TB] FAIL y_isolation got Q=%h want 7", Q);
      end
   endtask

   task automatic test_abort_clr();
      Y = 4'h5; SRC_B = 1'b1; LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      CLR_N = 1'b0;
      tick();
      tests_run++;
      if (Q !== 4'h0 || ENB_N !== 1'b1 || BUSY !== 1'b0 || LOAD_ACK !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL clr_abort got Q=%h ENB_N=%b BUSY=%b ACK=%b want 0 1 0 0",
                  Q, ENB_N, BUSY, LOAD_ACK);
      end
      CLR_N = 1'b1;
      tick();
      tests_run++;
      if (LOAD_ACK !== 1'b0 || Q !== 4'h0 || SEL !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL clr_after got ACK=%b Q=%h SEL=%b want 0 0 1", LOAD_ACK, Q, SEL);
      end
   endtask

   task automatic test_abort_reset();
      do_load(4'h9, 1'b0);
      Y = 4'hC; SRC_B = 1'b1; LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      tick();
      #2 RESET_N = 1'b0;
      #1;
      tests_run++;
      if (Q !== 4'h0 || SEL !== 1'b0 || ENB_N !== 1'b1 || BUSY !== 1'b0 || LOAD_ACK !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_capt got Q=%h SEL=%b ENB_N=%b BUSY=%b ACK=%b want 0 0 1 0 0",
                  Q, SEL, ENB_N, BUSY, LOAD_ACK);
      end
      #1 RESET_N = 1'b1;
      #1;
      tests_run++;
      if (Q !== 4'h0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_quiet got Q=%h BUSY=%b want 0 0", Q, BUSY);
      end
      tick();
      tests_run++;
      if (Q !== 4'h0 || LOAD_ACK !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_no_capture got Q=%h ACK=%b BUSY=%b want 0 0 0", Q, LOAD_ACK, BUSY);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_load_b();
      test_count_up();
      test_count_down();
      test_back_to_back();
      test_abort_clr();
      test_abort_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mux_load_counter
